// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time over valid/ready,
// a fixed number of wait states, then a single-cycle registered response.
module dmem_responder #(
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, next_state;

    logic [7:0]  count;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        accept;
    logic        commit;
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        in_range;

    logic [31:0] mem [DEPTH];

    assign accept    = (state == S_IDLE) && req_valid;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req_valid) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (count == 8'd1) next_state = S_RESP;
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the request is taken straight from the inputs instead of the latches.
    assign commit   = (next_state == S_RESP) && (state != S_RESP);
    assign c_write  = (state == S_IDLE) ? req_write : lat_write;
    assign c_addr   = (state == S_IDLE) ? req_addr  : lat_addr;
    assign c_wdata  = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign c_be     = (state == S_IDLE) ? req_be    : lat_be;
    assign in_range = c_addr < 32'(DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= 8'd0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                count     <= 8'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                count <= count - 8'd1;
            end
            rsp_valid <= commit;
            rsp_err   <= commit && !in_range;
            if (commit && in_range && !c_write)
                rsp_rdata <= mem[c_addr[ADDR_W-1:0]];
            else
                rsp_rdata <= 32'd0;
        end
    end

    // The array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && in_range && c_write) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) mem[c_addr[ADDR_W-1:0]][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) checked every cycle
// against a transaction-level model, plus literal response checks.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dmem_responder #(.DEPTH(128), .ADDR_W(7), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0])
    );

    dmem_responder #(.DEPTH(128), .ADDR_W(7), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s inst%0d: got %h expected %h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    // Transaction model: an accept at edge k commits at edge k+W, and the next accept is
    // allowed at edge k+W+2; busy covers every cycle in between.
    logic [31:0] smem [2][128];
    logic        pend [2];
    int          free_at [2];
    int          rsp_edge [2];
    logic        m_write [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be [2];
    logic        exp_valid [2];
    logic        exp_err [2];
    logic        exp_busy [2];
    logic [31:0] exp_rdata [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 128; a++) smem[i][a] = 32'd0;
            pend[i] = 1'b0; free_at[i] = 0; rsp_edge[i] = 0;
            exp_valid[i] = 1'b0; exp_err[i] = 1'b0; exp_busy[i] = 1'b0; exp_rdata[i] = 32'd0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
            exp_rdata[i] = 32'd0;
            if (reset) begin
                pend[i]     = 1'b0;
                free_at[i]  = cyc + 1;
                exp_busy[i] = 1'b0;
            end else begin
                if (!pend[i] && cyc >= free_at[i] && req_valid[i]) begin
                    pend[i] = 1'b1;
                    m_write[i] = req_write[i]; m_addr[i] = req_addr[i];
                    m_wdata[i] = req_wdata[i]; m_be[i] = req_be[i];
                    rsp_edge[i] = cyc + wc(i);
                    free_at[i]  = cyc + wc(i) + 2;
                end
                if (pend[i] && cyc == rsp_edge[i]) begin
                    pend[i] = 1'b0;
                    exp_valid[i] = 1'b1;
                    if (m_addr[i] >= 128) exp_err[i] = 1'b1;
                    else if (m_write[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[i][b]) smem[i][m_addr[i][6:0]][8*b +: 8] = m_wdata[i][8*b +: 8];
                    end else exp_rdata[i] = smem[i][m_addr[i][6:0]];
                end
                exp_busy[i] = cyc < free_at[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                chk("req_ready", i, req_ready[i], 1);
                chk("rsp_valid", i, rsp_valid[i], 0);
                chk("rsp_rdata", i, rsp_rdata[i], 0);
                chk("rsp_err",   i, rsp_err[i],   0);
                chk("busy",      i, busy[i],      0);
            end else begin
                chk("req_ready", i, req_ready[i], !exp_busy[i]);
                chk("rsp_valid", i, rsp_valid[i], exp_valid[i]);
                chk("rsp_rdata", i, rsp_rdata[i], exp_rdata[i]);
                chk("rsp_err",   i, rsp_err[i],   exp_err[i]);
                chk("busy",      i, busy[i],      exp_busy[i]);
            end
        end
    end

    task automatic applyStimulus(input int i, input logic w, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = addr;
        req_wdata[i] = wdata; req_be[i] = be;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk); #2;
                req_valid[i] = 1'b0;
                return;
            end
        end
        n_checks++; n_fail++;
        $display("[TB] FAIL accept_timeout inst%0d: got no accept required accept", i);
        req_valid[i] = 1'b0;
    endtask

    task automatic checkOutput(input int i, input string name, input logic [31:0] rdata,
                               input logic err, input int lat);
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                chk({name, "_rdata"}, i, rsp_rdata[i], rdata);
                chk({name, "_err"}, i, rsp_err[i], err);
                chk({name, "_latency"}, i, t, lat);
                @(posedge clk); #2;
                return;
            end
        end
        n_checks++; n_fail++;
        $display("[TB] FAIL %s_timeout inst%0d: got no rsp_valid required rsp_valid", name, i);
    endtask

    initial begin
        int accepts, pulses;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; req_be[i] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        applyStimulus(0, 1, 42, 32'hDEADBEEF, 4'hF);  checkOutput(0, "st42", 0, 0, 3);
        applyStimulus(0, 0, 42, 0, 0);                checkOutput(0, "ld42", 32'hDEADBEEF, 0, 3);

        applyStimulus(0, 1, 50, 32'h11223344, 4'hF);  checkOutput(0, "st50", 0, 0, 3);
        applyStimulus(0, 1, 50, 32'hAABBCCDD, 4'b0101); checkOutput(0, "st50be", 0, 0, 3);
        applyStimulus(0, 0, 50, 0, 0);                checkOutput(0, "ld50", 32'h11BB33DD, 0, 3);

        applyStimulus(0, 1, 72, 32'h0BADF00D, 4'hF);  checkOutput(0, "st72", 0, 0, 3);
        applyStimulus(0, 1, 200, 32'hFFFFFFFF, 4'hF); checkOutput(0, "st200", 0, 1, 3);
        applyStimulus(0, 0, 32'h80, 0, 0);            checkOutput(0, "ld128", 0, 1, 3);
        applyStimulus(0, 0, 32'h1000_0048, 0, 0);     checkOutput(0, "ldhigh", 0, 1, 3);
        applyStimulus(0, 0, 72, 0, 0);                checkOutput(0, "ld72", 32'h0BADF00D, 0, 3);
        applyStimulus(0, 1, 60, 32'h12345678, 4'h0);  checkOutput(0, "be0", 0, 0, 3);

        // Held request for 20 cycles: one accept every WAIT_CYCLES+2 cycles.
        accepts = 0; pulses = 0;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_be[0] = 4'hF;
        for (int j = 0; j < 20; j++) begin
            req_addr[0]  = (j % 2 == 0) ? 32'd60 : 32'd61;
            req_wdata[0] = 32'hA000_0000 + 32'(j);
            @(negedge clk);
            if (req_ready[0] && req_valid[0]) accepts++;
            if (rsp_valid[0]) pulses++;
            @(posedge clk); #2;
        end
        req_valid[0] = 1'b0;
        chk("held_accepts", 0, accepts, 5);
        chk("held_pulses", 0, pulses, 5);
        repeat (4) @(posedge clk); #2;

        applyStimulus(0, 1, 10, 32'h5, 4'hF);         checkOutput(0, "st10", 0, 0, 3);
        applyStimulus(0, 1, 10, 32'h99, 4'hF);
        @(posedge clk); #2 reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rstwait_valid", 0, rsp_valid[0], 0);
        end
        @(posedge clk); #2 reset = 1'b0;
        applyStimulus(0, 0, 10, 0, 0);                checkOutput(0, "ld10", 32'h5, 0, 3);

        // Reset during the response cycle keeps the committed store.
        applyStimulus(0, 1, 20, 32'hCAFE0001, 4'hF);
        for (int t = 0; t < 10 && !rsp_valid[0]; t++) @(negedge clk);
        chk("resp_seen", 0, rsp_valid[0], 1);
        #1 reset = 1'b1;
        #1 chk("rstresp_valid", 0, rsp_valid[0], 0);
        chk("rstresp_busy", 0, busy[0], 0);
        @(posedge clk); #2 reset = 1'b0;
        applyStimulus(0, 0, 20, 0, 0);                checkOutput(0, "ld20", 32'hCAFE0001, 0, 3);

        applyStimulus(1, 1, 42, 32'h7B, 4'hF);        checkOutput(1, "w0st42", 0, 0, 1);
        applyStimulus(1, 0, 42, 0, 0);                checkOutput(1, "w0ld42", 32'h7B, 0, 1);
        applyStimulus(1, 0, 200, 0, 0);               checkOutput(1, "w0ld200", 0, 1, 1);

        accepts = 0; pulses = 0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'd42;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (req_ready[1] && req_valid[1]) accepts++;
            if (rsp_valid[1]) pulses++;
            @(posedge clk); #2;
        end
        req_valid[1] = 1'b0;
        chk("w0_accepts", 1, accepts, 4);
        chk("w0_pulses", 1, pulses, 4);
        repeat (3) @(posedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
